// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ producers.
// Frame completion is timed by a cycle counter since the transmitter has no done flag.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_enable,
    input  logic [31:0]                cfg_cycles_per_bit,
    input  logic [3:0]                 cfg_data_bits,
    input  logic                       cfg_parity_en,
    input  logic [1:0]                 cfg_stop_bits,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [9*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [31:0]                Transmitter_Holding_Register,
    output logic [31:0]                Transmitter_Status,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       cfg_error
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = 37;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        SEND,
        GAP
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    thr_q, thr_d;
    logic [6:0]    fmt_q, fmt_d;
    logic          en_q, en_d;
    logic          err_q, err_d;

    logic [IW-1:0] win;
    logic          win_found;
    int            idx;
    logic          start_ok;
    logic [8:0]    mask;
    logic [8:0]    win_data;
    logic [3:0]    frame_bits;
    logic [CW-1:0] frame_cycles;

    assign err_d = (cfg_data_bits < 4'd5) || (cfg_data_bits > 4'd9)
                || !((cfg_stop_bits == 2'b01) || (cfg_stop_bits == 2'b10))
                || (cfg_cycles_per_bit == 32'd0);

    assign start_ok = cfg_enable && (|req_valid) && !err_q;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        win       = last_q;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win       = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < 9; i++) begin
            mask[i] = (i < int'(cfg_data_bits));
        end
    end

    assign win_data   = req_data[9*int'(win) +: 9];
    assign frame_bits = 4'd1 + cfg_data_bits + {3'b000, cfg_parity_en}
                      + ((cfg_stop_bits == 2'b10) ? 4'd2 : 4'd1);
    assign frame_cycles = CW'(frame_bits) * CW'(cfg_cycles_per_bit)
                        + CW'(GUARD_CYCLES);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gid_d     = gid_q;
        cnt_d     = cnt_q;
        thr_d     = thr_q;
        fmt_d     = fmt_q;
        en_d      = en_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = ARB;
            end
            ARB: begin
                if (win_found) begin
                    req_ready[win] = 1'b1;
                    state_d = SEND;
                    last_d  = win;
                    gid_d   = win;
                    thr_d   = win_data & mask;
                    fmt_d   = {cfg_stop_bits, cfg_parity_en, cfg_data_bits};
                    en_d    = 1'b1;
                    cnt_d   = (frame_cycles == '0) ? '0 : frame_cycles - CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                state_d = start_ok ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            gid_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= '0;
            fmt_q   <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            fmt_q   <= fmt_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign Transmitter_Holding_Register = {23'd0, thr_q};
    assign Transmitter_Status           = {24'd0, fmt_q, en_q};
    assign grant_id                     = gid_q;
    assign busy                         = (state_q != IDLE);
    assign frame_done                   = (state_q == GAP);
    assign cfg_error                    = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized self-checking bench for uart_tx_scheduler.
// Expected values come from an arithmetic model of the scheduling rules.
module tb_uart_tx_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_enable;
    logic [31:0]    cfg_cycles_per_bit;
    logic [3:0]     cfg_data_bits;
    logic           cfg_parity_en;
    logic [1:0]     cfg_stop_bits;
    logic [N-1:0]   req_valid;
    logic [9*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [31:0]    thr_o;
    logic [31:0]    status_o;
    logic [1:0]     grant_id;
    logic           busy;
    logic           frame_done;
    logic           cfg_error;

    int checks   = 0;
    int failures = 0;
    int model_last;

    uart_tx_scheduler #(.NUM_REQ(N), .GUARD_CYCLES(16)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .cfg_enable                   (cfg_enable),
        .cfg_cycles_per_bit           (cfg_cycles_per_bit),
        .cfg_data_bits                (cfg_data_bits),
        .cfg_parity_en                (cfg_parity_en),
        .cfg_stop_bits                (cfg_stop_bits),
        .req_valid                    (req_valid),
        .req_data                     (req_data),
        .req_ready                    (req_ready),
        .Transmitter_Holding_Register (thr_o),
        .Transmitter_Status           (status_o),
        .grant_id                     (grant_id),
        .busy                         (busy),
        .frame_done                   (frame_done),
        .cfg_error                    (cfg_error)
    );

    always #5 clk = ~clk;

    function automatic int ref_winner(int last, logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic longint ref_cycles(int db, int par, logic [1:0] stop, longint cpb);
        int nstop;
        nstop = (stop == 2'b10) ? 2 : 1;
        return longint'(1 + db + par + nstop) * cpb + 16;
    endfunction

    function automatic logic [31:0] ref_thr(logic [8:0] d, int db);
        logic [31:0] m;
        m = (32'd1 << db) - 32'd1;
        return {23'd0, d} & m;
    endfunction

    function automatic logic [31:0] ref_status(int db, int par, logic [1:0] stop);
        return {24'd0, stop, 1'(par), 4'(db), 1'b1};
    endfunction

    task automatic set_cfg(input logic en, input int cpb, input int db,
                           input int par, input logic [1:0] stop);
        cfg_enable         = en;
        cfg_cycles_per_bit = 32'(cpb);
        cfg_data_bits      = 4'(db);
        cfg_parity_en      = 1'(par);
        cfg_stop_bits      = stop;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        model_last = N - 1;
        @(negedge clk);
    endtask

    // Measures one frame: waits for req_ready, then counts cycles with Status[0] high.
    task automatic observe(input int budget, output logic [N-1:0] rdy,
                           output logic [1:0] gid, output logic [31:0] thr,
                           output logic [31:0] st, output int waits,
                           output longint send_len, output logic done,
                           output bit tmo);
        tmo = 0; waits = 0; send_len = 0; done = 0;
        gid = '0; thr = '0; st = '0;
        rdy = req_ready;
        while (rdy == '0 && waits < budget) begin
            @(negedge clk);
            waits++;
            rdy = req_ready;
        end
        if (rdy == '0) begin
            tmo = 1;
            return;
        end
        @(negedge clk);
        thr = thr_o; st = status_o; gid = grant_id;
        while (status_o[0] && send_len < 10000) begin
            send_len++;
            @(negedge clk);
        end
        done = frame_done;
        if (status_o[0]) tmo = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, thr_o, status_o, grant_id, busy, frame_done, cfg_error} !== '0) begin
            failures++;
            $display("FAIL reset_during got rdy=%b thr=%h st=%h", req_ready, thr_o, status_o);
        end
        do_reset();
        checks++;
        if ({req_ready, thr_o, status_o, grant_id, busy, frame_done, cfg_error} !== '0) begin
            failures++;
            $display("FAIL reset_after got rdy=%b thr=%h st=%h busy=%b err=%b",
                     req_ready, thr_o, status_o, busy, cfg_error);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] rdy; logic [1:0] gid; logic [31:0] thr, st;
        int w; longint sl; logic dn; bit tmo;
        do_reset();
        set_cfg(1, 10, 8, 0, 2'b01);
        req_data[8:0] = 9'h0A5;
        req_valid = 4'b0001;
        observe(50, rdy, gid, thr, st, w, sl, dn, tmo);
        req_valid = '0;
        checks++;
        if (tmo || rdy !== 4'b0001 || w != 1) begin
            failures++;
            $display("FAIL single_ready got rdy=%b waits=%0d tmo=%0d exp rdy=0001 waits=1", rdy, w, tmo);
        end
        checks++;
        if (thr !== ref_thr(9'h0A5, 8) || st !== ref_status(8, 0, 2'b01)) begin
            failures++;
            $display("FAIL single_regs got thr=%h st=%h exp thr=%h st=%h",
                     thr, st, ref_thr(9'h0A5, 8), ref_status(8, 0, 2'b01));
        end
        checks++;
        if (sl != ref_cycles(8, 0, 2'b01, 10)) begin
            failures++;
            $display("FAIL single_len got=%0d exp=%0d", sl, ref_cycles(8, 0, 2'b01, 10));
        end
        checks++;
        if (dn !== 1'b1 || status_o !== (ref_status(8, 0, 2'b01) & ~32'd1) || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_gap got done=%b st=%h busy=%b", dn, status_o, busy);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got done=%b busy=%b exp 0 0", frame_done, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] rdy; logic [1:0] gid; logic [31:0] thr, st;
        int w, exp; longint sl; logic dn; bit tmo;
        do_reset();
        set_cfg(1, 1, 8, 0, 2'b01);
        for (int i = 0; i < N; i++) req_data[9*i +: 9] = 9'($urandom);
        req_valid = '1;
        for (int f = 0; f < 5; f++) begin
            observe(50, rdy, gid, thr, st, w, sl, dn, tmo);
            exp = ref_winner(model_last, req_valid);
            checks++;
            if (tmo || rdy !== N'(1 << exp) || gid !== 2'(exp)) begin
                failures++;
                $display("FAIL rr_grant f=%0d got rdy=%b gid=%0d exp=%0d", f, rdy, gid, exp);
            end
            checks++;
            if (thr !== ref_thr(req_data[9*exp +: 9], 8) || sl != ref_cycles(8, 0, 2'b01, 1) || dn !== 1'b1) begin
                failures++;
                $display("FAIL rr_frame f=%0d got thr=%h len=%0d done=%b", f, thr, sl, dn);
            end
            if (f > 0) begin
                checks++;
                if (w != 1) begin
                    failures++;
                    $display("FAIL rr_gap f=%0d got waits=%0d exp=1", f, w);
                end
            end
            model_last = exp;
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_format();
        logic [N-1:0] rdy; logic [1:0] gid; logic [31:0] thr, st;
        int w; longint sl; logic dn; bit tmo;
        do_reset();
        set_cfg(1, 3, 9, 1, 2'b10);
        req_data[8:0] = 9'h1FF;
        @(negedge clk);
        req_valid = 4'b0001;
        observe(50, rdy, gid, thr, st, w, sl, dn, tmo);
        req_valid = '0;
        checks++;
        if (tmo || sl != ref_cycles(9, 1, 2'b10, 3) || thr !== ref_thr(9'h1FF, 9)
            || st !== ref_status(9, 1, 2'b10)) begin
            failures++;
            $display("FAIL fmt_9p2 got len=%0d thr=%h st=%h exp len=%0d thr=%h st=%h",
                     sl, thr, st, ref_cycles(9, 1, 2'b10, 3), ref_thr(9'h1FF, 9), ref_status(9, 1, 2'b10));
        end
        @(negedge clk);
        set_cfg(1, 1, 5, 0, 2'b01);
        @(negedge clk);
        req_valid = 4'b0001;
        observe(50, rdy, gid, thr, st, w, sl, dn, tmo);
        req_valid = '0;
        checks++;
        if (tmo || thr !== ref_thr(9'h1FF, 5) || sl != ref_cycles(5, 0, 2'b01, 1)) begin
            failures++;
            $display("FAIL fmt_5bit got thr=%h len=%0d exp thr=%h len=%0d",
                     thr, sl, ref_thr(9'h1FF, 5), ref_cycles(5, 0, 2'b01, 1));
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [N-1:0] rdy; logic [1:0] gid; logic [31:0] thr, st;
        int w; longint sl; logic dn; bit tmo; bit seen;
        int bdb[3]; logic [1:0] bst[3]; int bcpb[3];
        bdb = '{4, 8, 8}; bst = '{2'b01, 2'b11, 2'b01}; bcpb = '{5, 5, 0};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_cfg(1, bcpb[c], bdb[c], 0, bst[c]);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (cfg_error !== 1'b1) begin
                failures++;
                $display("FAIL illegal_err c=%0d got=%b exp=1", c, cfg_error);
            end
            req_valid = 4'b0001;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req_ready != '0 || busy) seen = 1;
            end
            checks++;
            if (seen) begin
                failures++;
                $display("FAIL illegal_grant c=%0d got grant/busy exp none", c);
            end
            set_cfg(1, 1, 8, 0, 2'b01);
            observe(10, rdy, gid, thr, st, w, sl, dn, tmo);
            req_valid = '0;
            checks++;
            if (tmo || rdy !== 4'b0001 || cfg_error !== 1'b0) begin
                failures++;
                $display("FAIL illegal_resume c=%0d got rdy=%b err=%b tmo=%0d", c, rdy, cfg_error, tmo);
            end
            model_last = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop();
        longint sl; int w; bit seen;
        do_reset();
        set_cfg(1, 2, 8, 0, 2'b01);
        req_valid = '1;
        w = 0;
        while (req_ready == '0 && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        sl = 0;
        while (status_o[0] && sl < 10000) begin
            sl++;
            if (sl == 5) cfg_enable = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (sl != ref_cycles(8, 0, 2'b01, 2) || frame_done !== 1'b1) begin
            failures++;
            $display("FAIL endrop_frame got len=%0d done=%b exp len=%0d done=1",
                     sl, frame_done, ref_cycles(8, 0, 2'b01, 2));
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != '0 || busy) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL endrop_idle got grant/busy after disable exp none");
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rdy; logic [1:0] gid; logic [31:0] thr, st;
        int w, exp; longint sl; logic dn; bit tmo;
        do_reset();
        set_cfg(1, 4, 8, 0, 2'b01);
        req_valid = 4'b0100;
        w = 0;
        while (req_ready == '0 && w < 20) begin @(negedge clk); w++; end
        for (int i = 0; i < 5; i++) @(negedge clk);
        checks++;
        if (status_o[0] !== 1'b1 || grant_id !== 2'(ref_winner(N - 1, 4'b0100))) begin
            failures++;
            $display("FAIL rstmid_pre got st=%h gid=%0d", status_o, grant_id);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, thr_o, status_o, grant_id, busy, frame_done, cfg_error} !== '0) begin
            failures++;
            $display("FAIL rstmid_clear got thr=%h st=%h gid=%0d busy=%b", thr_o, status_o, grant_id, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
        req_valid = '1;
        observe(20, rdy, gid, thr, st, w, sl, dn, tmo);
        exp = ref_winner(model_last, 4'b1111);
        checks++;
        if (tmo || rdy !== N'(1 << exp)) begin
            failures++;
            $display("FAIL rstmid_first got rdy=%b exp=%b", rdy, N'(1 << exp));
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] rdy; logic [1:0] gid; logic [31:0] thr, st;
        int w, exp, db, par, cpb; longint sl; logic dn; bit tmo;
        logic [1:0] stop; logic [N-1:0] v;
        do_reset();
        for (int it = 0; it < 10; it++) begin
            db   = $urandom_range(9, 5);
            par  = $urandom_range(1, 0);
            stop = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01;
            cpb  = $urandom_range(5, 1);
            v    = N'($urandom_range(15, 1));
            for (int i = 0; i < N; i++) req_data[9*i +: 9] = 9'($urandom);
            set_cfg(1, cpb, db, par, stop);
            @(negedge clk);
            @(negedge clk);
            req_valid = v;
            observe(20, rdy, gid, thr, st, w, sl, dn, tmo);
            req_valid = '0;
            exp = ref_winner(model_last, v);
            checks++;
            if (tmo || rdy !== N'(1 << exp) || gid !== 2'(exp)) begin
                failures++;
                $display("FAIL rand_grant it=%0d v=%b got rdy=%b gid=%0d exp=%0d", it, v, rdy, gid, exp);
            end
            checks++;
            if (thr !== ref_thr(req_data[9*exp +: 9], db) || st !== ref_status(db, par, stop)
                || sl != ref_cycles(db, par, stop, longint'(cpb))) begin
                failures++;
                $display("FAIL rand_frame it=%0d got thr=%h st=%h len=%0d exp thr=%h st=%h len=%0d",
                         it, thr, st, sl, ref_thr(req_data[9*exp +: 9], db),
                         ref_status(db, par, stop), ref_cycles(db, par, stop, longint'(cpb)));
            end
            model_last = exp;
            @(negedge clk);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        set_cfg(0, 1, 8, 0, 2'b01);
        test_reset();
        test_single();
        test_round_robin();
        test_format();
        test_illegal();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART `transmitter` between `NUM_REQ` byte producers. It validates and latches frame configuration and loads the winner's data into `Transmitter_Holding_Register`. It also drives `Transmitter_Status`, including the enable/reset bit 0 and the frame format. The transmitter has no done flag, so frame completion is timed by an internal cycle counter. The block sits between the register file/requesters and the `transmitter` instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GUARD_CYCLES`, default 16: extra cycles added after each computed frame time before the transmitter is released.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_enable`  in  1  scheduler enable.
- `cfg_cycles_per_bit`  in  32  clock cycles per UART bit.
- `cfg_data_bits`  in  4  data bits per frame; legal values 5..9.
- `cfg_parity_en`  in  1  parity bit present.
- `cfg_stop_bits`  in  2  2'b01 = one stop bit, 2'b10 = two stop bits; other values illegal.
- `req_valid`  in  NUM_REQ  per-requester data valid.
- `req_data`  in  9*NUM_REQ  requester i's data in bits [9i+8:9i].
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `Transmitter_Holding_Register`  out  32  data to the transmitter.
- `Transmitter_Status`  out  32  bit 0 enable; [4:1] data bits; [5] parity; [7:6] stop bits; [31:8] = 0.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last grant.
- `busy`  out  1  high in ARB, SEND and GAP.
- `frame_done`  out  1  one-cycle pulse at end of each frame.
- `cfg_error`  out  1  configuration illegal, registered.

## Operation
- States: IDLE, ARB, SEND, GAP.
- `cfg_error` is registered every cycle as: `cfg_data_bits` outside 5..9, OR `cfg_stop_bits` not in {01,10}, OR `cfg_cycles_per_bit` == 0.
- IDLE:
  - `Transmitter_Status[0]` = 0, holding the transmitter in reset.
  - Goes to ARB when `cfg_enable` & |`req_valid` & !`cfg_error`.
- ARB (one cycle):
  - Winner is the first set `req_valid` searching from `last_grant`+1 modulo NUM_REQ.
  - `req_ready[winner]` = 1 combinationally this cycle only.
  - If `req_valid` dropped and no requester is valid, return to IDLE without a grant.
- At the ARB→SEND edge:
  - `Transmitter_Holding_Register` = zero-extended `req_data[winner]` masked to `cfg_data_bits` LSBs.
  - `Transmitter_Status` = {24'b0, stop, parity, data_bits, 1'b1}.
  - `grant_id` and `last_grant` ← winner.
  - Counter ← frame_cycles − 1.
- Frame length:
  - frame_bits = 1 + data_bits + parity_en + stop_count, range 7..13, 4 bits.
  - frame_cycles = frame_bits × `cfg_cycles_per_bit` + `GUARD_CYCLES`, computed in 37 bits with no truncation.
  - The counter is 37 bits wide.
- SEND:
  - Counter decrements each cycle.
  - When the counter is 0, go to GAP.
  - Config inputs are ignored during SEND because the config was snapshotted at ARB.
- GAP (one cycle):
  - `Transmitter_Status[0]` = 0, resetting the transmitter FSM; bits [7:1] are held.
  - `frame_done` = 1.
  - Next state is ARB if `cfg_enable` & |`req_valid` & !`cfg_error`, else IDLE.
- `cfg_enable` deasserted mid-frame: the current frame completes, then no new grants.
- `cfg_error` asserting mid-frame: the frame completes, then the block goes to IDLE.
- Requesters must hold `req_data` stable while `req_valid` is high. Data is transferred on `req_valid` & `req_ready`.
- Reset values: all outputs 0, state IDLE, `last_grant` = NUM_REQ−1 so requester 0 wins first.
- Reset mid-frame: outputs clear immediately (asynchronous), `Transmitter_Status[0]` drops and the frame aborts.

## Timing
- Valid seen in IDLE at cycle 0 → ARB with `req_ready` high at cycle 1 → `Transmitter_Status[0]` = 1 from cycle 2.
- SEND lasts exactly frame_cycles cycles, GAP lasts 1 cycle.
- With back-to-back requests, GAP → ARB → SEND gives 2 cycles with `Transmitter_Status[0]` = 0 between frames.
- `busy` is high from the ARB cycle through the GAP cycle inclusive.
- `cfg_error` changes take effect on the IDLE/GAP decision one cycle after the input change.

## Test plan
- Single requester: NUM_REQ=4, `req_valid`=4'b0001, data 9'h0A5, cpb=10, 8 data bits, no parity, 1 stop.
  - `req_ready[0]` at cycle 1.
  - THR = 32'hA5, Status = 32'h51 from cycle 2 for 100+16 = 116 cycles.
  - Then `frame_done` for 1 cycle, Status[0] = 0.
- Round-robin: all four requesters valid continuously.
  - Grants are 0,1,2,3,0; each pair of frames is separated by exactly 2 cycles with Status[0] = 0.
- Format math: 9 bits, parity, 2 stop, cpb=3.
  - SEND lasts 13×3+16 = 55 cycles.
  - Data 9'h1FF with 5 data bits gives THR = 32'h1F.
- Illegal config: `cfg_data_bits`=4'd4, or stop=2'b11, or cpb=0.
  - `cfg_error` = 1, no `req_ready` ever.
  - Fixing the config resumes service.
- Mid-frame events:
  - `cfg_enable` low mid-SEND → the frame completes, `frame_done` pulses, then IDLE with no grant despite valid requests.
  - Async `rst` mid-SEND → all outputs 0 in the same cycle.
  - After release, requester 0 wins first.
